// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-granular block copy that drives the byte-addressed
// memory port (combinational read, write on rising clk when mem_WE is high).
// Words move from src_addr to dst_addr in ascending address order, one READ
// cycle followed by one WRITE cycle per word. Pointers wrap modulo
// 2^ADDR_WIDTH. No alignment check is made. When dst lies inside
// (src, src+len), already-written words are re-read, so the data smears.
//
// Optional feature macro: MEM_COPY_FILL_EN adds fill_mode/fill_data and a
// FILL state that writes one constant word per cycle to the destination.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          request, sampled only in IDLE
//   src_addr       first source byte address
//   dst_addr       first destination byte address
//   len_words      number of words to move
//   fill_mode      (MEM_COPY_FILL_EN) select fill instead of copy
//   fill_data      (MEM_COPY_FILL_EN) fill pattern
//   busy           high while READ/WRITE/FILL
//   done           one-cycle completion pulse
//   mem_WE         memory write enable
//   mem_ADDR       memory byte address
//   mem_WD         memory write data
//   mem_RD         memory read data, combinational from mem_ADDR
module mem_copy_engine #(
  parameter int unsigned BYTE_SIZE  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  src_addr,
  input  logic [ADDR_WIDTH-1:0]  dst_addr,
  input  logic [LEN_WIDTH-1:0]   len_words,
`ifdef MEM_COPY_FILL_EN
  input  logic                   fill_mode,
  input  logic [BYTE_SIZE*8-1:0] fill_data,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   mem_WE,
  output logic [ADDR_WIDTH-1:0]  mem_ADDR,
  output logic [BYTE_SIZE*8-1:0] mem_WD,
  input  logic [BYTE_SIZE*8-1:0] mem_RD
);

  localparam int unsigned DATA_W = BYTE_SIZE * 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
`ifdef MEM_COPY_FILL_EN
    ,
    S_FILL  = 3'd4
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  // Data register doubles as the write-data output; it holds between words.
  logic [DATA_W-1:0]       wd_q, wd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  // State, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state, pointer updates, and next-cycle output decode.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    wd_d    = wd_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = len_words;
          state_d = (len_words == '0) ? S_DONE : S_READ;
`ifdef MEM_COPY_FILL_EN
          if (fill_mode && (len_words != '0)) begin
            wd_d    = fill_data;
            state_d = S_FILL;
          end
`endif
        end
      end
      S_READ: begin
        wd_d    = mem_RD;
        src_d   = src_q + ADDR_WIDTH'(BYTE_SIZE);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        dst_d   = dst_q + ADDR_WIDTH'(BYTE_SIZE);
        rem_d   = rem_q - LEN_WIDTH'(1);
        state_d = (rem_q == LEN_WIDTH'(1)) ? S_DONE : S_READ;
      end
`ifdef MEM_COPY_FILL_EN
      S_FILL: begin
        dst_d   = dst_q + ADDR_WIDTH'(BYTE_SIZE);
        rem_d   = rem_q - LEN_WIDTH'(1);
        state_d = (rem_q == LEN_WIDTH'(1)) ? S_DONE : S_FILL;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs for the upcoming cycle are a pure function of the next state
    // and next pointers, so they register without adding a cycle of latency.
    busy_d = 1'b0;
    done_d = 1'b0;
    we_d   = 1'b0;
    addr_d = '0;
    case (state_d)
      S_READ: begin
        busy_d = 1'b1;
        addr_d = src_d;
      end
      S_WRITE: begin
        busy_d = 1'b1;
        we_d   = 1'b1;
        addr_d = dst_d;
      end
`ifdef MEM_COPY_FILL_EN
      S_FILL: begin
        busy_d = 1'b1;
        we_d   = 1'b1;
        addr_d = dst_d;
      end
`endif
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_WE   = we_q;
  assign mem_ADDR = addr_q;
  assign mem_WD   = wd_q;

endmodule
